// File: rtl/complement_pkg.sv
// Shared definitions for the sequential two's-complement unit.
// Contents: operand mode encodings, FSM state encoding, and a helper that
// resolves the negate decision from mode, operand MSB and external sign.
package complement_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_CNEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Decide whether the accepted operand gets negated.
  function automatic logic neg_for_mode(input logic [1:0] mode,
                                        input logic       msb,
                                        input logic       sign);
    logic n;
    case (mode)
      MODE_PASS: n = 1'b0;
      MODE_NEG:  n = 1'b1;
      MODE_ABS:  n = msb;
      default:   n = sign;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/complement_2s_chunk.sv
// One N-bit slice of a ripple two's-complement negation.
// Ports:
//   x    : input slice
//   neg  : 1 -> y = ~x + cin, 0 -> y = x
//   cin  : carry from the previous (less significant) slice
//   y    : output slice
//   cout : carry into the next slice (0 when not negating)
module complement_2s_chunk #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  input  logic         cin,
  output logic [N-1:0] y,
  output logic         cout
);

  logic [N:0] sum;

  assign sum  = {1'b0, ~x} + (N+1)'(cin);
  assign y    = neg ? sum[N-1:0] : x;
  assign cout = neg & sum[N];

endmodule

// File: rtl/complement_2s_seq.sv
// Multi-cycle two's-complement unit: pass, negate, absolute value or
// conditional negate of a WIDTH-bit operand, CHUNK bits per cycle LSB first.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready combinational)
//   in_data/in_mode/in_sign : operand, mode (see complement_pkg), sign for mode 11
//   out_valid/out_ready   : result handshake
//   out_data              : result
//   out_ovf               : most-negative value was negated
//   out_zero              : result is zero
//   out_neg               : a negation was applied
module complement_2s_seq
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject parameter sets that cannot be split into whole chunks.
  generate
    if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("complement_2s_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [31:0]        sh_c;
  logic [CHUNK-1:0]   x_c, y_c;
  logic               cout_c;
  logic [WIDTH-1:0]   res_ins_c;
  logic               accept_c;

  // Select the active chunk and merge its result back into the accumulator.
  assign sh_c      = 32'(cnt_q) * CHUNK;
  assign x_c       = CHUNK'(op_q >> sh_c);
  assign res_ins_c = (res_q & ~(CHUNK_MASK << sh_c)) | (WIDTH'(y_c) << sh_c);

  complement_2s_chunk #(.N(CHUNK)) u_chunk (
    .x    (x_c),
    .neg  (neg_q),
    .cin  (carry_q),
    .y    (y_c),
    .cout (cout_c)
  );

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept_c = in_valid && in_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        res_d   = res_ins_c;
        carry_d = cout_c;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
          valid_d = 1'b1;
          ovf_d   = neg_q && (op_q == MOST_NEG);
          zero_d  = (res_ins_c == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept is only possible from IDLE or a consumed DONE.
    if (accept_c) begin
      state_d = BUSY;
      op_d    = in_data;
      neg_d   = neg_for_mode(in_mode, in_data[WIDTH-1], in_sign);
      carry_d = neg_d;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;

endmodule

// File: tb/tb_complement_2s_seq.sv
// Self-checking bench for complement_2s_seq. Three instances:
//   0: WIDTH=8  CHUNK=2  (directed cases, hold, back-to-back, reset abort)
//   1: WIDTH=16 CHUNK=4  (mode sweep, random backpressure)
//   2: WIDTH=8  CHUNK=8  (mode sweep, single BUSY cycle)
module tb_complement_2s_seq;
  import complement_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid [3];
  logic        out_ready[3];
  logic        in_sign  [3];
  logic [1:0]  in_mode  [3];
  logic [15:0] in_data  [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        out_ovf  [3];
  logic        out_zero [3];
  logic        out_neg  [3];
  logic [15:0] out_data [3];
  logic [7:0]  od0, od2;
  logic [15:0] od1;

  assign out_data[0] = 16'(od0);
  assign out_data[1] = od1;
  assign out_data[2] = 16'(od2);

  complement_2s_seq #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0][7:0]),
    .in_mode(in_mode[0]), .in_sign(in_sign[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0),
    .out_ovf(out_ovf[0]), .out_zero(out_zero[0]), .out_neg(out_neg[0])
  );

  complement_2s_seq #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_mode(in_mode[1]), .in_sign(in_sign[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1),
    .out_ovf(out_ovf[1]), .out_zero(out_zero[1]), .out_neg(out_neg[1])
  );

  complement_2s_seq #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2][7:0]),
    .in_mode(in_mode[2]), .in_sign(in_sign[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2),
    .out_ovf(out_ovf[2]), .out_zero(out_zero[2]), .out_neg(out_neg[2])
  );

  function automatic int wid(input int id);
    return (id == 1) ? 16 : 8;
  endfunction

  function automatic int lat(input int id);
    return (id == 2) ? 1 : 4;
  endfunction

  // Reference: arithmetic negation modulo 2^w, decided from the mode table.
  function automatic logic [15:0] ref_res(input int w, input logic [15:0] d,
                                          input logic [1:0] m, input logic s,
                                          output logic neg, output logic ovf,
                                          output logic zero);
    int unsigned mask, val, r;
    mask = (32'd1 << w) - 32'd1;
    val  = 32'(d) & mask;
    case (m)
      2'd0:    neg = 1'b0;
      2'd1:    neg = 1'b1;
      2'd2:    neg = ((val >> (w - 1)) & 32'd1) == 32'd1;
      default: neg = s;
    endcase
    r    = neg ? (((32'd1 << w) - val) & mask) : val;
    ovf  = neg && (val == (32'd1 << (w - 1)));
    zero = (r == 0);
    return 16'(r);
  endfunction

  task automatic chk(input int id, input string tag,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, id, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [15:0] d, input logic [1:0] m,
                      input logic s);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid[id] = 1'b1;
    in_data[id]  = d;
    in_mode[id]  = m;
    in_sign[id]  = s;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (in_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(id, "accept", 16'(ok), 16'd1);
    if (ok) @(posedge clk);
    #1;
    // Scramble inputs after the accepting edge; they must be ignored.
    in_valid[id] = 1'b0;
    in_data[id]  = 16'($urandom);
    in_mode[id]  = 2'($urandom);
    in_sign[id]  = 1'($urandom);
  endtask

  task automatic check_out(input int id, input string tag, input logic [15:0] ed,
                           input logic eo, input logic ez, input logic en);
    chk(id, {tag, "_valid"}, 16'(out_valid[id]), 16'd1);
    chk(id, {tag, "_data"},  out_data[id], ed);
    chk(id, {tag, "_ovf"},   16'(out_ovf[id]), 16'(eo));
    chk(id, {tag, "_zero"},  16'(out_zero[id]), 16'(ez));
    chk(id, {tag, "_neg"},   16'(out_neg[id]), 16'(en));
  endtask

  // Called just after the accepting edge; checks latency, BUSY in_ready and
  // the result, optionally with random backpressure in DONE.
  task automatic wait_result(input int id, input logic [15:0] ed, input logic eo,
                             input logic ez, input logic en, input bit bp,
                             input bit consume);
    for (int j = 0; j < lat(id); j++) begin
      @(negedge clk);
      if (bp) out_ready[id] = 1'($urandom);
      #1;
      chk(id, "busy_out_valid", 16'(out_valid[id]), 16'd0);
      chk(id, "busy_in_ready", 16'(in_ready[id]), 16'd0);
    end
    if (!consume) begin
      @(negedge clk);
      out_ready[id] = 1'b0;
      #1;
      check_out(id, "hold0", ed, eo, ez, en);
      chk(id, "hold0_in_ready", 16'(in_ready[id]), 16'd0);
      return;
    end
    for (int h = 0; h < 32; h++) begin
      @(negedge clk);
      out_ready[id] = (bp && h < 31) ? 1'($urandom) : 1'b1;
      #1;
      check_out(id, "done", ed, eo, ez, en);
      chk(id, "done_in_ready", 16'(in_ready[id]), 16'(out_ready[id]));
      if (out_ready[id]) break;
    end
    @(negedge clk);
    #1;
    chk(id, "idle_out_valid", 16'(out_valid[id]), 16'd0);
    chk(id, "idle_in_ready", 16'(in_ready[id]), 16'd1);
  endtask

  task automatic xact_dir(input logic [15:0] d, input logic [1:0] m, input logic s,
                          input logic [15:0] ed, input logic eo, input logic ez,
                          input logic en);
    send(0, d, m, s);
    wait_result(0, ed, eo, ez, en, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d, ed;
    logic        s, en, eo, ez;

    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      in_sign[i]   = 1'b0;
      in_mode[i]   = MODE_PASS;
      in_data[i]   = 16'h0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk(i, "rst_out_valid", 16'(out_valid[i]), 16'd0);
      chk(i, "rst_out_data", out_data[i], 16'd0);
      chk(i, "rst_out_ovf", 16'(out_ovf[i]), 16'd0);
      chk(i, "rst_out_zero", 16'(out_zero[i]), 16'd0);
      chk(i, "rst_out_neg", 16'(out_neg[i]), 16'd0);
      chk(i, "rst_in_ready", 16'(in_ready[i]), 16'd1);
    end
    rst_n = 1'b1;

    // Directed cases, WIDTH=8 CHUNK=2, no backpressure.
    xact_dir(16'h01, MODE_NEG,  1'b0, 16'hFF, 1'b0, 1'b0, 1'b1);
    xact_dir(16'h80, MODE_NEG,  1'b0, 16'h80, 1'b1, 1'b0, 1'b1);
    xact_dir(16'h00, MODE_NEG,  1'b0, 16'h00, 1'b0, 1'b1, 1'b1);
    xact_dir(16'hF6, MODE_ABS,  1'b0, 16'h0A, 1'b0, 1'b0, 1'b1);
    xact_dir(16'h05, MODE_ABS,  1'b0, 16'h05, 1'b0, 1'b0, 1'b0);
    xact_dir(16'h05, MODE_CNEG, 1'b1, 16'hFB, 1'b0, 1'b0, 1'b1);
    xact_dir(16'h05, MODE_CNEG, 1'b0, 16'h05, 1'b0, 1'b0, 1'b0);
    xact_dir(16'hA5, MODE_PASS, 1'b0, 16'hA5, 1'b0, 1'b0, 1'b0);

    // Hold in DONE with toggling inputs, then back-to-back accept.
    send(0, 16'h03, MODE_NEG, 1'b0);
    wait_result(0, 16'hFD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_mode[0]  = MODE_NEG;
      in_data[0]  = 16'($urandom);
      #1;
      check_out(0, "hold", 16'hFD, 1'b0, 1'b0, 1'b1);
      chk(0, "hold_in_ready", 16'(in_ready[0]), 16'd0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_mode[0]   = MODE_NEG;
    in_data[0]   = 16'h02;
    #1;
    chk(0, "b2b_in_ready", 16'(in_ready[0]), 16'd1);
    check_out(0, "b2b_prev", 16'hFD, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_data[0]  = 16'h77;
    wait_result(0, 16'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of BUSY aborts the operation.
    send(0, 16'h55, MODE_NEG, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "abort_out_valid", 16'(out_valid[0]), 16'd0);
    chk(0, "abort_out_data", out_data[0], 16'd0);
    chk(0, "abort_in_ready", 16'(in_ready[0]), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(0, "post_rst_in_ready", 16'(in_ready[0]), 16'd1);
    chk(0, "post_rst_out_valid", 16'(out_valid[0]), 16'd0);
    xact_dir(16'h02, MODE_NEG, 1'b0, 16'hFE, 1'b0, 1'b0, 1'b1);

    // Mode sweeps with random backpressure against the reference model.
    for (int id = 1; id < 3; id++) begin
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < 256; i++) begin
          if (id == 1) begin
            d = {8'($urandom), 8'(i)};
            if (i == 0) d = 16'h8000;
            if (i == 1) d = 16'h0000;
            if (i == 2) d = 16'hFFFF;
            if (i == 3) d = 16'h7FFF;
          end else begin
            d = 16'(i);
          end
          s  = 1'($urandom);
          ed = ref_res(wid(id), d, 2'(m), s, en, eo, ez);
          send(id, d, 2'(m), s);
          wait_result(id, ed, eo, ez, en, 1'b1, 1'b1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
